// File: rtl/letc_core_wb_scoreboard.sv
// In-order issue scoreboard: RAW hazard detection, forwarding-tag selection, one entry per issued instruction.
// Hazard/fwd/issue_ready are combinational; state updates next cycle; full or hazard deasserts issue_ready.
module letc_core_wb_scoreboard #(
    parameter int DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_rd_idx,
    input  logic             issue_rd_we,
    input  logic [4:0]       issue_rs1_idx,
    input  logic             issue_rs1_used,
    input  logic [4:0]       issue_rs2_idx,
    input  logic             issue_rs2_used,
    output logic [TAG_W-1:0] issue_tag,
    input  logic             mark_valid,
    input  logic [TAG_W-1:0] mark_tag,
    input  logic             retire_valid,
    input  logic             flush,
    output logic             hazard,
    output logic             rs1_fwd_valid,
    output logic [TAG_W-1:0] rs1_fwd_tag,
    output logic             rs2_fwd_valid,
    output logic [TAG_W-1:0] rs2_fwd_tag,
    output logic [TAG_W:0]   count
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] ready_q, ready_d;
    logic [DEPTH-1:0] rd_we_q, rd_we_d;
    logic [4:0]       rd_idx_q [DEPTH];
    logic [4:0]       rd_idx_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic [4:0]       src_idx [2];
    logic [1:0]       src_used;
    logic [1:0]       m_hit;
    logic [1:0]       m_rdy;
    logic [TAG_W-1:0] m_tag [2];
    logic             accept;
    logic             retire_en;

    assign src_idx[0]  = issue_rs1_idx;
    assign src_idx[1]  = issue_rs2_idx;
    assign src_used[0] = issue_rs1_used;
    assign src_used[1] = issue_rs2_used;

    // Walk oldest to youngest from head; the last hit is the youngest producer.
    always_comb begin
        logic [TAG_W-1:0] e;
        e = '0;
        for (int s = 0; s < 2; s++) begin
            m_hit[s] = 1'b0;
            m_rdy[s] = 1'b0;
            m_tag[s] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                e = head_q + TAG_W'(i);
                if (src_used[s] && (src_idx[s] != 5'd0) && valid_q[e] && rd_we_q[e]
                    && (rd_idx_q[e] == src_idx[s])) begin
                    m_hit[s] = 1'b1;
                    m_rdy[s] = ready_q[e];
                    m_tag[s] = e;
                end
            end
        end
    end

    assign hazard        = (m_hit[0] && !m_rdy[0]) || (m_hit[1] && !m_rdy[1]);
    assign rs1_fwd_valid = m_hit[0] && m_rdy[0];
    assign rs2_fwd_valid = m_hit[1] && m_rdy[1];
    assign rs1_fwd_tag   = rs1_fwd_valid ? m_tag[0] : '0;
    assign rs2_fwd_tag   = rs2_fwd_valid ? m_tag[1] : '0;
    assign issue_ready   = (count_q != (TAG_W+1)'(DEPTH)) && !hazard;
    assign issue_tag     = tail_q;
    assign count         = count_q;

    assign accept    = issue_valid && issue_ready;
    assign retire_en = retire_valid && (count_q != '0);

    always_comb begin
        valid_d  = valid_q;
        ready_d  = ready_q;
        rd_we_d  = rd_we_q;
        rd_idx_d = rd_idx_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q + (TAG_W+1)'(accept) - (TAG_W+1)'(retire_en);
        if (mark_valid && valid_q[mark_tag]) begin
            ready_d[mark_tag] = 1'b1;
        end
        if (retire_en) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
        end
        if (accept) begin
            valid_d[tail_q]  = 1'b1;
            ready_d[tail_q]  = 1'b0;
            rd_we_d[tail_q]  = issue_rd_we;
            rd_idx_d[tail_q] = issue_rd_idx;
            tail_d           = tail_q + TAG_W'(1);
        end
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            ready_q <= '0;
            rd_we_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            ready_q <= ready_d;
            rd_we_q <= rd_we_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Register indices are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        rd_idx_q <= rd_idx_d;
    end

    a_no_retire_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(retire_valid && !flush && (count_q == '0)));

endmodule
